// File: rtl/voxel_bram_axi_slave.sv
// +----------------------------------------------------------------------------+
// | voxel_bram_axi_slave: AXI4 slave over a single-clock BRAM (FIXED/INCR).    |
// | Optional WRAP bursts with VOXEL_BRAM_WRAP_EN.         Revision: 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module voxel_bram_axi_slave #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [1:0]              s_awburst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [1:0]              s_arburst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_off    = $clog2(c_strb_w);
    localparam int c_idx_w  = $clog2(MEM_WORDS);

    localparam logic [1:0] c_burst_fixed = 2'd0;
    localparam logic [1:0] c_burst_incr  = 2'd1;
    localparam logic [1:0] c_burst_wrap  = 2'd2;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

`ifdef VOXEL_BRAM_WRAP_EN
    localparam bit c_wrap_en = 1'b1;
`else
    localparam bit c_wrap_en = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        logic len_ok;
        len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        case (burst)
            c_burst_fixed, c_burst_incr: burst_err = 1'b0;
            c_burst_wrap:                burst_err = !(c_wrap_en && len_ok);
            default:                     burst_err = 1'b1;
        endcase
    endfunction

    // WRAP stays inside the aligned block of len+1 words.
    function automatic logic [c_idx_w-1:0] next_idx(input logic [c_idx_w-1:0] idx,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [c_idx_w-1:0] mask;
        logic [c_idx_w-1:0] inc;
        mask = c_idx_w'(len);
        inc  = idx + c_idx_w'(1);
        case (burst)
            c_burst_fixed: next_idx = idx;
            c_burst_wrap:  next_idx = (idx & ~mask) | (inc & mask);
            default:       next_idx = inc;
        endcase
    endfunction

    logic                    init_q, init_d;
    wstate_t                 wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]     wid_q, wid_d;
    logic [c_idx_w-1:0]      widx_q, widx_d;
    logic [7:0]              wlen_q, wlen_d;
    logic [1:0]              wburst_q, wburst_d;
    logic [7:0]              wbeat_q, wbeat_d;
    logic                    werr_q, werr_d;
    logic                    wmis_q, wmis_d;
    logic [1:0]              bresp_q, bresp_d;

    rstate_t                 rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]     rid_q, rid_d;
    logic [c_idx_w-1:0]      ridx_q, ridx_d;
    logic [7:0]              rlen_q, rlen_d;
    logic [1:0]              rburst_q, rburst_d;
    logic [7:0]              rbeat_q, rbeat_d;
    logic                    rerr_q, rerr_d;

    logic                    mem_we;
    logic                    mem_re;
    logic                    w_last_beat;
    logic                    w_mismatch;
    logic                    r_last_beat;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0]   bram_dout;

    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr, s_araddr};

    always_comb begin
        init_d      = 1'b1;
        wstate_d    = wstate_q;
        wid_d       = wid_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        wburst_d    = wburst_q;
        wbeat_d     = wbeat_q;
        werr_d      = werr_q;
        wmis_d      = wmis_q;
        bresp_d     = bresp_q;
        mem_we      = 1'b0;
        w_last_beat = (wbeat_q == wlen_q);
        w_mismatch  = (s_wlast != w_last_beat);
        case (wstate_q)
            W_IDLE: begin
                if (init_q && s_awvalid) begin
                    wid_d    = s_awid;
                    widx_d   = s_awaddr[c_off +: c_idx_w];
                    wlen_d   = s_awlen;
                    wburst_d = s_awburst;
                    wbeat_d  = 8'd0;
                    werr_d   = burst_err(s_awburst, s_awlen);
                    wmis_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_wvalid) begin
                    // A wlast mismatch stops memory updates from that beat on.
                    mem_we  = !werr_q && !wmis_q && !w_mismatch;
                    wmis_d  = wmis_q || w_mismatch;
                    wbeat_d = wbeat_q + 8'd1;
                    widx_d  = next_idx(widx_q, wlen_q, wburst_q);
                    if (w_last_beat) begin
                        bresp_d  = (werr_q || wmis_q || w_mismatch) ? c_resp_slverr : c_resp_okay;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d    = rstate_q;
        rid_d       = rid_q;
        ridx_d      = ridx_q;
        rlen_d      = rlen_q;
        rburst_d    = rburst_q;
        rbeat_d     = rbeat_q;
        rerr_d      = rerr_q;
        r_last_beat = (rbeat_q == rlen_q);
        case (rstate_q)
            R_IDLE: begin
                if (init_q && s_arvalid) begin
                    rid_d    = s_arid;
                    ridx_d   = s_araddr[c_off +: c_idx_w];
                    rlen_d   = s_arlen;
                    rburst_d = s_arburst;
                    rbeat_d  = 8'd0;
                    rerr_d   = burst_err(s_arburst, s_arlen);
                    rstate_d = R_FETCH;
                end
            end
            R_FETCH: rstate_d = R_DATA;
            R_DATA: begin
                if (s_rready) begin
                    if (r_last_beat) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rbeat_d  = rbeat_q + 8'd1;
                        ridx_d   = next_idx(ridx_q, rlen_q, rburst_q);
                        rstate_d = R_FETCH;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q   <= 1'b0;
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            widx_q   <= '0;
            wlen_q   <= '0;
            wburst_q <= '0;
            wbeat_q  <= '0;
            werr_q   <= 1'b0;
            wmis_q   <= 1'b0;
            bresp_q  <= c_resp_okay;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            ridx_q   <= '0;
            rlen_q   <= '0;
            rburst_q <= '0;
            rbeat_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            init_q   <= init_d;
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            widx_q   <= widx_d;
            wlen_q   <= wlen_d;
            wburst_q <= wburst_d;
            wbeat_q  <= wbeat_d;
            werr_q   <= werr_d;
            wmis_q   <= wmis_d;
            bresp_q  <= bresp_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            ridx_q   <= ridx_d;
            rlen_q   <= rlen_d;
            rburst_q <= rburst_d;
            rbeat_q  <= rbeat_d;
            rerr_q   <= rerr_d;
        end
    end

    // Read-first BRAM: the read in the same edge as a write sees the old word.
    assign mem_re = (rstate_q == R_FETCH) && !rerr_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (s_wstrb[b]) mem[widx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end
        end
        if (mem_re) bram_dout <= mem[ridx_q];
    end

    assign s_awready = init_q && (wstate_q == W_IDLE);
    assign s_wready  = (wstate_q == W_DATA);
    assign s_bvalid  = (wstate_q == W_RESP);
    assign s_bresp   = bresp_q;
    assign s_bid     = wid_q;

    assign s_arready = init_q && (rstate_q == R_IDLE);
    assign s_rvalid  = (rstate_q == R_DATA);
    assign s_rlast   = s_rvalid && r_last_beat;
    assign s_rresp   = (s_rvalid && rerr_q) ? c_resp_slverr : c_resp_okay;
    assign s_rdata   = (s_rvalid && !rerr_q) ? bram_dout : '0;
    assign s_rid     = rid_q;

endmodule

`default_nettype wire

// File: tb/tb_voxel_bram_axi_slave.sv
// +----------------------------------------------------------------------------+
// | tb_voxel_bram_axi_slave: directed bench for voxel_bram_axi_slave.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_voxel_bram_axi_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_awid;
    logic [27:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [3:0]  s_arid;
    logic [27:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;

    int          checks = 0;
    int          errors = 0;

    logic [63:0] wbuf    [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_lat  [16];
    logic [3:0]  rd_id;
    logic [1:0]  bresp_o;
    logic [3:0]  bid_o;

    always #5 clk = ~clk;

    voxel_bram_axi_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [27:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [7:0] strb,
                             input logic [3:0] id, input int flip,
                             output logic [1:0] resp, output logic [3:0] bid);
        int cnt;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
        cnt = 0;
        while (!s_awready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        chk("awready", s_awready, 1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        chk("wready_after_aw", s_wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            s_wdata  = wbuf[i];
            s_wstrb  = strb;
            s_wlast  = (i == int'(len)) ^ (i == flip);
            s_wvalid = 1'b1;
            cnt = 0;
            while (!s_wready && cnt < 50) begin @(posedge clk); #1; cnt++; end
            chk("wready", s_wready, 1);
            @(posedge clk); #1;
            chk("bvalid_timing", s_bvalid, (i == int'(len)));
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s_bready = 1'b1;
        cnt = 0;
        while (!s_bvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
        chk("bvalid", s_bvalid, 1);
        resp = s_bresp;
        bid  = s_bid;
        @(posedge clk); #1;
        s_bready = 1'b0;
        chk("awready_after_b", s_awready, 1);
    endtask

    task automatic axi_read(input logic [27:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
        int cnt;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
        cnt = 0;
        while (!s_arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        chk("arready", s_arready, 1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        s_rready  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            cnt = 0;
            while (!s_rvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
            chk("rvalid", s_rvalid, 1);
            rd_data[i] = s_rdata;
            rd_resp[i] = s_rresp;
            rd_last[i] = s_rlast;
            rd_lat[i]  = cnt;
            rd_id      = s_rid;
            @(posedge clk); #1;
        end
        s_rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] old5;
        int          cnt;
        rst_n = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arburst = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", s_awready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_wready",  s_wready, 0);
        chk("rst_bvalid",  s_bvalid, 0);
        chk("rst_rvalid",  s_rvalid, 0);
        chk("rst_rlast",   s_rlast, 0);
        chk("rst_rdata",   s_rdata, 0);
        chk("rst_bresp",   s_bresp, 0);
        chk("rst_rresp",   s_rresp, 0);
        chk("rst_ids",     {s_bid, s_rid}, 0);
        rst_n = 1'b1;
        #1;
        chk("awready_before_edge", s_awready, 0);
        @(posedge clk); #1;
        chk("awready_first_edge", s_awready, 1);
        chk("arready_first_edge", s_arready, 1);

        // INCR write then INCR read of words 8..11
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        axi_write(28'h040, 8'd3, 2'd1, 8'hFF, 4'h5, -1, bresp_o, bid_o);
        chk("incr_bresp", bresp_o, 2'b00);
        chk("incr_bid", bid_o, 4'h5);
        axi_read(28'h040, 8'd3, 2'd1, 4'h9);
        chk("incr_rid", rd_id, 4'h9);
        chk("incr_d0", rd_data[0], 64'h11);
        chk("incr_d1", rd_data[1], 64'h22);
        chk("incr_d2", rd_data[2], 64'h33);
        chk("incr_d3", rd_data[3], 64'h44);
        chk("incr_last", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);
        chk("incr_resp", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 8'h00);
        chk("incr_lat0", rd_lat[0], 1);
        chk("incr_lat1", rd_lat[1], 1);

        // Byte strobes
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        axi_write(28'h080, 8'd0, 2'd1, 8'hFF, 4'h1, -1, bresp_o, bid_o);
        wbuf[0] = 64'h0;
        axi_write(28'h080, 8'd0, 2'd1, 8'h0F, 4'h2, -1, bresp_o, bid_o);
        axi_read(28'h080, 8'd0, 2'd1, 4'h3);
        chk("strb_data", rd_data[0], 64'hFFFF_FFFF_0000_0000);
        chk("strb_rlast", rd_last[0], 1);

        // FIXED write keeps hammering the same word
        wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3;
        axi_write(28'h100, 8'd2, 2'd0, 8'hFF, 4'h4, -1, bresp_o, bid_o);
        chk("fixed_bresp", bresp_o, 2'b00);
        axi_read(28'h100, 8'd0, 2'd1, 4'h4);
        chk("fixed_data", rd_data[0], 64'd3);

        // Reserved burst type: consumed, SLVERR, no write
        wbuf[0] = 64'hDEAD_BEEF_0000_0001; wbuf[1] = 64'hDEAD_BEEF_0000_0002;
        axi_write(28'h040, 8'd1, 2'd3, 8'hFF, 4'hA, -1, bresp_o, bid_o);
        chk("rsvd_bresp", bresp_o, 2'b10);
        chk("rsvd_bid", bid_o, 4'hA);
        axi_read(28'h040, 8'd0, 2'd1, 4'h0);
        chk("rsvd_untouched", rd_data[0], 64'h11);

        // Early wlast on beat 0 of a two-beat burst
        axi_write(28'h200, 8'd1, 2'd1, 8'hFF, 4'hB, 0, bresp_o, bid_o);
        chk("wlast_bresp", bresp_o, 2'b10);

        // WRAP read of words 0..3 starting at word 3
        wbuf[0] = 64'hA; wbuf[1] = 64'hB; wbuf[2] = 64'hC; wbuf[3] = 64'hD;
        axi_write(28'h000, 8'd3, 2'd1, 8'hFF, 4'h6, -1, bresp_o, bid_o);
        axi_read(28'h018, 8'd3, 2'd2, 4'h7);
`ifdef VOXEL_BRAM_WRAP_EN
        chk("wrap_d0", rd_data[0], 64'hD);
        chk("wrap_d1", rd_data[1], 64'hA);
        chk("wrap_d2", rd_data[2], 64'hB);
        chk("wrap_d3", rd_data[3], 64'hC);
        chk("wrap_resp", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 8'h00);
`else
        chk("wrap_d0", rd_data[0], 64'h0);
        chk("wrap_d1", rd_data[1], 64'h0);
        chk("wrap_d2", rd_data[2], 64'h0);
        chk("wrap_d3", rd_data[3], 64'h0);
        chk("wrap_resp", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 8'hAA);
`endif
        chk("wrap_last", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);

        // Reset while beat 1 of a 4-beat read is presented
        s_arid = 4'h2; s_araddr = 28'h000; s_arlen = 8'd3; s_arburst = 2'd1; s_arvalid = 1'b1;
        cnt = 0;
        while (!s_arready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        s_rready  = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_beat0", s_rdata, 64'hA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid_beat1_valid", s_rvalid, 1);
        chk("rstmid_beat1", s_rdata, 64'hB);
        rst_n = 1'b0;
        #1;
        chk("rstmid_rvalid_drop", s_rvalid, 0);
        s_rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rstmid_arready_pre", s_arready, 0);
        @(posedge clk); #1;
        chk("rstmid_arready", s_arready, 1);
        axi_read(28'h010, 8'd1, 2'd1, 4'hC);
        chk("rstmid_new0", rd_data[0], 64'hC);
        chk("rstmid_new1", rd_data[1], 64'hD);
        chk("rstmid_newlast", {rd_last[0], rd_last[1]}, 2'b01);

        // Same-cycle read and write of word 5: read-first
        old5 = 64'h5555_0000_0000_0005;
        wbuf[0] = old5;
        axi_write(28'h028, 8'd0, 2'd1, 8'hFF, 4'h1, -1, bresp_o, bid_o);
        s_awid = 4'h3; s_awaddr = 28'h028; s_awlen = 8'd0; s_awburst = 2'd1; s_awvalid = 1'b1;
        s_arid = 4'h4; s_araddr = 28'h028; s_arlen = 8'd0; s_arburst = 2'd1; s_arvalid = 1'b1;
        chk("rw_both_ready", {s_awready, s_arready}, 2'b11);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        s_wdata = 64'h0123_4567_89AB_CDEF; s_wstrb = 8'hFF; s_wlast = 1'b1; s_wvalid = 1'b1;
        chk("rw_wready", s_wready, 1);
        @(posedge clk); #1;
        s_wvalid = 1'b0; s_wlast = 1'b0;
        chk("rw_rvalid", s_rvalid, 1);
        chk("rw_old", s_rdata, old5);
        chk("rw_bvalid", s_bvalid, 1);
        s_rready = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0; s_bready = 1'b0;
        axi_read(28'h028, 8'd0, 2'd1, 4'h4);
        chk("rw_new", rd_data[0], 64'h0123_4567_89AB_CDEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
